// File: rtl/csa_selfrepair_adder.sv
`default_nettype none
// ============================================================================
// Module   : csa_selfrepair_adder
// Purpose  : Self-repairing carry-select adder. It is built from NPHYS
//            physical 2-bit carry-select cells, NLOG = WIDTH/2 of which are
//            steered into the datapath. A built-in self-test checks every
//            physical cell exhaustively (16 vectors) against an arithmetic
//            golden model. A single MAP cycle then routes each logical cell
//            to the next fault-free physical cell.
// Options  : `define CSA_FAULT_INJ_EN adds input fault_inj[NPHYS-1:0]. While
//            fault_inj[p] is high, bit 0 of physical cell p's output is
//            inverted, in both TEST and RUN.
// Revision : 1.0 - initial release
// ============================================================================
module csa_selfrepair_adder #(
  parameter int WIDTH  = 8,
  parameter int SPARES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bist_start,
  input  logic [WIDTH-1:0]          x,
  input  logic [WIDTH-1:0]          y,
  input  logic                      cin,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          sum,
  output logic                      cout,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [WIDTH/2+SPARES-1:0] fault_map,
  output logic [2:0]                fault_count
`ifdef CSA_FAULT_INJ_EN
  ,
  input  logic [WIDTH/2+SPARES-1:0] fault_inj
`endif
);

  localparam int NLOG  = WIDTH / 2;
  localparam int NPHYS = NLOG + SPARES;
  localparam int PW    = $clog2(NPHYS);
  // The test counter is {cell index, vector}, so its width is PW + 4.
  localparam int CW    = PW + 4;
  localparam logic [CW-1:0] TEST_LAST = CW'(NPHYS * 16 - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TEST = 3'd1;
  localparam logic [2:0] S_MAP  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("csa_selfrepair_adder: WIDTH must be even and at least 4");
  end
  if (SPARES < 1 || SPARES > 4) begin : g_bad_spares
    $error("csa_selfrepair_adder: SPARES must be between 1 and 4");
  end

  // Reference result for vector {a1,b1,a0,b0}. It is written with the
  // '+' operator so that it stays independent of the gate-level cells.
  function automatic logic [5:0] f_golden(input logic [3:0] v);
    logic [2:0] t0;
    logic [2:0] t1;
    t0 = {1'b0, v[3], v[1]} + {1'b0, v[2], v[0]};
    t1 = t0 + 3'd1;
    return {t1[2], t0[2], t1[1], t0[1], t1[0], t0[0]};
  endfunction

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NPHYS-1:0]    fault_map_q, fault_map_d;
  logic [PW-1:0]       steer_q [NLOG];
  logic [PW-1:0]       steer_d [NLOG];
  logic [WIDTH-1:0]    x_q, y_q;
  logic                cin_q, v1_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q, out_valid_q;

  logic [1:0]          w_pa   [NPHYS];
  logic [1:0]          w_pb   [NPHYS];
  logic [5:0]          w_raw  [NPHYS];
  logic [5:0]          w_cell [NPHYS];
  logic [3:0]          w_vec;
  logic [PW-1:0]       w_tcell;
  logic                w_mismatch;
  int                  w_pop;
  int                  w_rank;
  logic [WIDTH-1:0]    w_sum;
  logic                w_c;
  logic [5:0]          w_sel;

  assign w_vec   = cnt_q[3:0];
  assign w_tcell = cnt_q[CW-1:4];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. bist_start is only honoured outside TEST and MAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN, S_FAIL: if (bist_start) state_d = S_TEST;
      S_TEST:                if (cnt_q == TEST_LAST) state_d = S_MAP;
      S_MAP:                 state_d = (w_pop <= SPARES) ? S_RUN : S_FAIL;
      default:               state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    in_ready = (state_q == S_RUN);
    done     = (state_q == S_RUN);
    busy     = (state_q == S_TEST) || (state_q == S_MAP);
    fail     = (state_q == S_FAIL);
  end

  // The test counter advances only in TEST and rests at zero elsewhere.
  always_comb begin
    cnt_d = (state_q == S_TEST) ? cnt_q + 1'b1 : '0;
  end

  // Cell operands: the broadcast test vector in TEST; otherwise the slice of
  // the logical cell currently steered onto this physical cell.
  always_comb begin
    for (int p = 0; p < NPHYS; p++) begin
      w_pa[p] = 2'b00;
      w_pb[p] = 2'b00;
      if (state_q == S_TEST) begin
        w_pa[p] = {w_vec[3], w_vec[1]};
        w_pb[p] = {w_vec[2], w_vec[0]};
      end else begin
        for (int i = 0; i < NLOG; i++) begin
          if (steer_q[i] == PW'(p)) begin
            w_pa[p] = x_q[2*i +: 2];
            w_pb[p] = y_q[2*i +: 2];
          end
        end
      end
    end
  end

  // Physical 2-bit carry-select cells, with optional bit-0 fault injection.
  for (genvar p = 0; p < NPHYS; p++) begin : g_cell
    logic w_p0, w_g0, w_p1, w_g1, w_k0, w_k1;
    assign w_p0 = w_pa[p][0] ^ w_pb[p][0];
    assign w_g0 = w_pa[p][0] & w_pb[p][0];
    assign w_p1 = w_pa[p][1] ^ w_pb[p][1];
    assign w_g1 = w_pa[p][1] & w_pb[p][1];
    assign w_k0 = w_g0;
    assign w_k1 = w_g0 | w_p0;
    assign w_raw[p] = {w_g1 | (w_p1 & w_k1), w_g1 | (w_p1 & w_k0),
                       w_p1 ^ w_k1, w_p1 ^ w_k0, ~w_p0, w_p0};
`ifdef CSA_FAULT_INJ_EN
    assign w_cell[p] = w_raw[p] ^ {5'b00000, fault_inj[p]};
`else
    assign w_cell[p] = w_raw[p];
`endif
  end

  assign w_mismatch = (w_cell[w_tcell] != f_golden(w_vec));

  // Fault map: cleared on entry to TEST; a flagged cell stays flagged.
  always_comb begin
    fault_map_d = fault_map_q;
    if (state_d == S_TEST && state_q != S_TEST) fault_map_d = '0;
    else if (state_q == S_TEST && w_mismatch)   fault_map_d[w_tcell] = 1'b1;
  end

  // Saturating population count of the fault map.
  always_comb begin
    w_pop = 0;
    for (int p = 0; p < NPHYS; p++) w_pop = w_pop + int'(fault_map_q[p]);
    fault_count = (w_pop > 7) ? 3'd7 : 3'(w_pop);
  end

  // Steering: in MAP, logical cell i takes the i-th healthy physical cell.
  always_comb begin
    w_rank = 0;
    for (int i = 0; i < NLOG; i++) steer_d[i] = steer_q[i];
    if (state_q == S_MAP) begin
      for (int p = 0; p < NPHYS; p++) begin
        if (!fault_map_q[p]) begin
          for (int i = 0; i < NLOG; i++) begin
            if (w_rank == i) steer_d[i] = PW'(p);
          end
          w_rank = w_rank + 1;
        end
      end
    end
  end

  // Carry-select chain through the steered cells.
  always_comb begin
    w_c   = cin_q;
    w_sum = '0;
    w_sel = '0;
    for (int j = 0; j < NLOG; j++) begin
      w_sel           = w_cell[steer_q[j]];
      w_sum[2*j +: 2] = w_c ? {w_sel[3], w_sel[1]} : {w_sel[2], w_sel[0]};
      w_c             = w_c ? w_sel[5] : w_sel[4];
    end
  end

  // BIST bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      fault_map_q <= '0;
      for (int i = 0; i < NLOG; i++) steer_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      fault_map_q <= fault_map_d;
      for (int i = 0; i < NLOG; i++) steer_q[i] <= steer_d[i];
    end
  end

  // Two-stage RUN pipeline; anything in flight is dropped when RUN is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      cin_q       <= 1'b0;
      v1_q        <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        x_q   <= x;
        y_q   <= y;
        cin_q <= cin;
      end
      v1_q        <= in_valid && in_ready && (state_d == S_RUN);
      out_valid_q <= v1_q && (state_d == S_RUN);
      if (v1_q) begin
        sum_q  <= w_sum;
        cout_q <= w_c;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
  assign fault_map = fault_map_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_selfrepair_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_selfrepair_adder
// Purpose  : Directed self-checking bench for csa_selfrepair_adder
//            (WIDTH=8, SPARES=2). The fault-injection scenarios are built
//            only when CSA_FAULT_INJ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_selfrepair_adder;

  logic       clk;
  logic       rst_n;
  logic       bist_start;
  logic [7:0] x, y;
  logic       cin;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       fail;
  logic [5:0] fault_map;
  logic [2:0] fault_count;
`ifdef CSA_FAULT_INJ_EN
  logic [5:0] fault_inj;
`endif

  int n_checks;
  int n_errors;
  int lat;

  csa_selfrepair_adder #(.WIDTH(8), .SPARES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bist_start  (bist_start),
    .x           (x),
    .y           (y),
    .cin         (cin),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sum         (sum),
    .cout        (cout),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .fault_map   (fault_map),
    .fault_count (fault_count)
`ifdef CSA_FAULT_INJ_EN
    ,
    .fault_inj   (fault_inj)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse bist_start and count cycles until done or fail (bounded).
  task automatic run_bist(output int cycles);
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    cycles = 0;
    while (!(done || fail) && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  // One isolated addition; result is expected two edges after capture.
  task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic ec);
    x = a; y = b; cin = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_ov_early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_ov"},   32'(out_valid), 32'd1);
    check({tag, "_sum"},  32'(sum),       32'(es));
    check({tag, "_cout"}, 32'(cout),      32'(ec));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; bist_start = 1'b0;
    x = '0; y = '0; cin = 1'b0; in_valid = 1'b0;
`ifdef CSA_FAULT_INJ_EN
    fault_inj = '0;
`endif
    #1;
    check("rst_sum",   32'(sum),         32'd0);
    check("rst_cout",  32'(cout),        32'd0);
    check("rst_ov",    32'(out_valid),   32'd0);
    check("rst_rdy",   32'(in_ready),    32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_fail",  32'(fail),        32'd0);
    check("rst_map",   32'(fault_map),   32'd0);
    check("rst_count", 32'(fault_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Fault-free BIST: 97 cycles from the bist_start edge to done.
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    check("test_busy", 32'(busy),     32'd1);
    check("test_rdy",  32'(in_ready), 32'd0);
    lat = 0;
    while (!done && lat < 300) begin
      tick();
      lat++;
    end
    check("bist0_lat",   32'(lat),         32'd97);
    check("bist0_map",   32'(fault_map),   32'd0);
    check("bist0_count", 32'(fault_count), 32'd0);
    check("bist0_busy",  32'(busy),        32'd0);
    do_add("add_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

    // Four back-to-back accepts, results on four consecutive cycles.
    x = 8'h01; y = 8'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    x = 8'h02; y = 8'h02;
    tick();
    check("b2b0_ov",  32'(out_valid), 32'd1);
    check("b2b0_sum", 32'(sum),       32'h02);
    x = 8'h03; y = 8'h03;
    tick();
    check("b2b1_ov",  32'(out_valid), 32'd1);
    check("b2b1_sum", 32'(sum),       32'h04);
    x = 8'hFF; y = 8'hFF;
    tick();
    in_valid = 1'b0;
    check("b2b2_ov",   32'(out_valid), 32'd1);
    check("b2b2_sum",  32'(sum),       32'h06);
    check("b2b2_cout", 32'(cout),      32'd0);
    tick();
    check("b2b3_ov",   32'(out_valid), 32'd1);
    check("b2b3_sum",  32'(sum),       32'hFE);
    check("b2b3_cout", 32'(cout),      32'd1);
    tick();
    check("b2b_end_ov", 32'(out_valid), 32'd0);

`ifdef CSA_FAULT_INJ_EN
    // One faulty cell, repaired by a spare.
    fault_inj = 6'b000010;
    run_bist(lat);
    check("f1_lat",   32'(lat),         32'd97);
    check("f1_map",   32'(fault_map),   32'b000010);
    check("f1_count", 32'(fault_count), 32'd1);
    check("f1_done",  32'(done),        32'd1);
    do_add("f1_add", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Two faulty cells, both spares consumed.
    fault_inj = 6'b001001;
    run_bist(lat);
    check("f2_map",   32'(fault_map),   32'b001001);
    check("f2_count", 32'(fault_count), 32'd2);
    check("f2_done",  32'(done),        32'd1);
    do_add("f2_add", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    // Three faulty cells: not repairable.
    fault_inj = 6'b010101;
    run_bist(lat);
    check("f3_lat",   32'(lat),         32'd97);
    check("f3_count", 32'(fault_count), 32'd3);
    check("f3_fail",  32'(fail),        32'd1);
    check("f3_done",  32'(done),        32'd0);
    check("f3_rdy",   32'(in_ready),    32'd0);
    fault_inj = '0;
`endif

    // Reset in the middle of TEST aborts everything.
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    repeat (40) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_busy",  32'(busy),        32'd0);
    check("mr_done",  32'(done),        32'd0);
    check("mr_fail",  32'(fail),        32'd0);
    check("mr_rdy",   32'(in_ready),    32'd0);
    check("mr_ov",    32'(out_valid),   32'd0);
    check("mr_sum",   32'(sum),         32'd0);
    check("mr_cout",  32'(cout),        32'd0);
    check("mr_map",   32'(fault_map),   32'd0);
    check("mr_count", 32'(fault_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("mr_idle_busy", 32'(busy), 32'd0);
    check("mr_idle_done", 32'(done), 32'd0);
    run_bist(lat);
    check("mr_lat",  32'(lat),  32'd97);
    check("mr_done2", 32'(done), 32'd1);
    do_add("add_1234", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csa_selfrepair_adder.md
CSA_SELFREPAIR_ADDER -- requirements
Module: csa_selfrepair_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning adder operand width; it must be even and at least 4.
REQ-002 SHALL have parameter SPARES, default 2, meaning the number of spare 2-bit carry-select cells; it must be between 1 and 4.
REQ-003 Derived values: NLOG = WIDTH/2 logical cells; NPHYS = NLOG+SPARES physical cells.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 bist_start  input  1  one-cycle pulse that starts the self-test and repair sequence.
REQ-007 x, y  input  WIDTH  operands.
REQ-008 cin  input  1  carry in.
REQ-009 in_valid  input  1  operand qualifier.
REQ-010 in_ready  output  1  high only in RUN state.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout  output  1  registered carry out.
REQ-013 out_valid  output  1  result qualifier.
REQ-014 busy  output  1  high in TEST or MAP state.
REQ-015 done  output  1  high in RUN state.
REQ-016 fail  output  1  high in FAIL state.
REQ-017 fault_map  output  NPHYS  bit p is set when physical cell p failed self-test.
REQ-018 fault_count  output  3  population count of fault_map, saturating at 7.

Function
REQ-019 Each physical cell SHALL take {a1,b1,a0,b0} and produce a 6-bit output {c_cin1, c_cin0, s1_cin1, s1_cin0, s0_cin1, s0_cin0}, i.e. 2-bit sums and carry-outs for carry-in 0 and carry-in 1.
REQ-020 The FSM SHALL have states IDLE, TEST, MAP, RUN and FAIL; the reset state is IDLE.
- IDLE -> TEST on bist_start.
- RUN -> TEST on bist_start.
- FAIL -> TEST on bist_start.
- bist_start is ignored in TEST and MAP.
REQ-021 TEST SHALL apply vectors 0..15 to physical cells 0..NPHYS-1 in ascending order, one vector per cycle, for NPHYS*16 cycles.
- The cell output is compared in the same cycle against an arithmetic golden model.
- Any mismatch in any bit sets fault_map[p]; a flagged cell stays flagged.
REQ-022 On entering TEST, fault_map and fault_count SHALL clear.
REQ-023 MAP SHALL last exactly one cycle and then go to RUN if fault_count <= SPARES, otherwise to FAIL.
REQ-024 In MAP, logical cell i SHALL be steered to the i-th fault-free physical cell in ascending index order; the steering is registered and held until the next TEST.
REQ-025 RUN datapath: each logical cell j handles bits 2j+1:2j; cell 0 is selected by cin and cell j by the selected carry of cell j-1.
REQ-026 RUN pipeline:
- x, y and cin are captured when in_valid && in_ready.
- sum and cout are registered one cycle later.
- out_valid follows in_valid with a latency of 2 cycles.
- There is no backpressure; back-to-back accepts give one result per cycle, in order.
REQ-027 In-flight results SHALL be discarded when RUN is left; out_valid is forced to 0 outside RUN.
REQ-028 TEST + MAP latency SHALL be exactly NPHYS*16+1 cycles from the bist_start edge to done=1.

Reset
REQ-029 While rst_n=0, the following SHALL be 0: state (IDLE), fault_map, fault_count, steering registers, sum, cout, out_valid, in_ready, busy, done and fail.
REQ-030 Reset asserted mid-TEST or mid-RUN SHALL abort immediately with no partial map retained; a new bist_start is required before use.

Configuration
REQ-031 Macro CSA_FAULT_INJ_EN defined: the module SHALL add input fault_inj [NPHYS-1:0]; while fault_inj[p]=1, physical cell p's output bit 0 is inverted in both TEST and RUN.
REQ-032 Macro CSA_FAULT_INJ_EN undefined: the port and the inversion logic SHALL be absent, and cells are fault-free by construction.

Verification (WIDTH=8, SPARES=2, NPHYS=6, CSA_FAULT_INJ_EN defined)
REQ-033 No faults; pulse bist_start -> done=1 after 97 cycles, fault_map=0, fault_count=0; then x=0xFF, y=0x01, cin=0 -> 2 cycles later sum=0x00, cout=1, out_valid=1.
REQ-034 fault_inj=6'b000010; BIST -> fault_map=6'b000010, fault_count=1, done=1; then x=0xA5, y=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-035 fault_inj=6'b001001; BIST -> fault_map=6'b001001, fault_count=2; then x=0x7F, y=0x01, cin=0 -> sum=0x80, cout=0.
REQ-036 fault_inj=6'b010101; BIST -> fault_count=3, fail=1, done=0, in_ready=0.
REQ-037 Assert rst_n=0 at TEST cycle 40 -> all outputs 0 and state IDLE; release, pulse bist_start -> done after 97 cycles.
REQ-038 In RUN, 4 back-to-back valid inputs (1+1, 2+2, 3+3, 0xFF+0xFF) -> 4 consecutive out_valid cycles with sum 0x02, 0x04, 0x06, 0xFE (cout=1 on the last).
